signal_filter: RTL and testbench

- Single-bit glitch/debounce filter for a noisy, clock-synchronous input.
- `sig_out` changes to a new level only after `sig_in` has held that level for `N` consecutive clock samples; otherwise it holds its last value.
- Used as a leaf block between a raw control input and downstream logic that needs a stable level.

---
 rtl/signal_filter.sv | 47 ++++
 tb/tb_signal_filter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/signal_filter.sv
// Debounce filter: sig_out follows sig_in only after N consecutive equal samples.
// Latency N edges from the first new-level sample; N-1 history flops plus one output flop.
module signal_filter #(
  parameter int N = 4
) (
  output logic sig_out,
  input  logic clock,
  input  logic reset,
  input  logic sig_in
);

  generate
    if (N < 2 || N > 16) begin : g_bad_n
      $error("signal_filter: N must be in 2..16");
    end
  endgenerate

  logic [N-2:0] hist_q, hist_d;
  logic         out_q, out_d;
  logic [N-1:0] window;

  // The current sample completes the window, so the output can switch on the Nth edge.
  assign window = {hist_q, sig_in};

  always_comb begin
    hist_d = window[N-2:0];
    out_d  = out_q;
    if (&window) begin
      out_d = 1'b1;
    end else if (~|window) begin
      out_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hist_q <= '0;
      out_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      out_q  <= out_d;
    end
  end

  assign sig_out = out_q;

endmodule

// File: tb/tb_signal_filter.sv
// Directed bench for signal_filter at N=4 plus N=2 and N=8 instances.
module tb_signal_filter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst4, in4, out4;
  logic rst2, in2, out2;
  logic rst8, in8, out8;

  int total = 0;
  int bad   = 0;

  signal_filter #(.N(4)) u_dut4 (.sig_out(out4), .clock(clk), .reset(rst4), .sig_in(in4));
  signal_filter #(.N(2)) u_dut2 (.sig_out(out2), .clock(clk), .reset(rst2), .sig_in(in2));
  signal_filter #(.N(8)) u_dut8 (.sig_out(out8), .clock(clk), .reset(rst8), .sig_in(in8));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst4 = 1'b0;
    in4  = 1'b1;
    #1;
    total++;
    if (out4 !== 1'b0) begin
      bad++;
      $display("FAIL reset_async: got %b want 0", out4);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (out4 !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold edge %0d: got %b want 0", i + 1, out4);
      end
    end
    rst4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (out4 !== (i == 3)) begin
        bad++;
        $display("FAIL reset_release edge %0d: got %b want %b", i + 1, out4, (i == 3));
      end
    end
  endtask

  task automatic test_rise();
    logic [6:0] stim;
    logic [6:0] expv;
    stim = 7'b1111011;
    expv = 7'b1000000;
    rst4 = 1'b0;
    in4  = 1'b0;
    tick();
    rst4 = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in4 = stim[i];
      tick();
      total++;
      if (out4 !== expv[i]) begin
        bad++;
        $display("FAIL rise edge %0d: got %b want %b", i + 1, out4, expv[i]);
      end
    end
  endtask

  task automatic test_high_glitch();
    logic [5:0] stim;
    stim = 6'b111010;
    for (int i = 0; i < 6; i++) begin
      in4 = stim[i];
      tick();
      total++;
      if (out4 !== 1'b1) begin
        bad++;
        $display("FAIL high_glitch edge %0d: got %b want 1", i + 1, out4);
      end
    end
  endtask

  task automatic test_fall();
    logic [11:0] stim;
    logic [11:0] expv;
    // lows x4 (fall), highs x4 (rise), lows x3 then a high (no fall)
    stim = 12'b1000_1111_0000;
    expv = 12'b1111_1000_0111;
    for (int i = 0; i < 12; i++) begin
      in4 = stim[i];
      tick();
      total++;
      if (out4 !== expv[i]) begin
        bad++;
        $display("FAIL fall edge %0d: got %b want %b", i + 1, out4, expv[i]);
      end
    end
  endtask

  task automatic test_idempotence();
    for (int i = 0; i < 4; i++) begin
      in4 = 1'b1;
      tick();
      total++;
      if (out4 !== 1'b1) begin
        bad++;
        $display("FAIL idempotent edge %0d: got %b want 1", i + 1, out4);
      end
    end
  endtask

  task automatic test_mid_reset();
    in4  = 1'b1;
    rst4 = 1'b0;
    #1;
    total++;
    if (out4 !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_async: got %b want 0", out4);
    end
    tick();
    total++;
    if (out4 !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_hold: got %b want 0", out4);
    end
    rst4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (out4 !== (i == 3)) begin
        bad++;
        $display("FAIL mid_reset_requal edge %0d: got %b want %b", i + 1, out4, (i == 3));
      end
    end
  endtask

  task automatic test_sweep_n2();
    logic [7:0] stim;
    logic [7:0] expv;
    stim = 8'b0010_1101;
    expv = 8'b0111_1000;
    rst2 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in2 = stim[i];
      tick();
      total++;
      if (out2 !== expv[i]) begin
        bad++;
        $display("FAIL sweep_n2 edge %0d: got %b want %b", i + 1, out2, expv[i]);
      end
    end
  endtask

  task automatic test_sweep_n8();
    logic [31:0] stim;
    logic [31:0] expv;
    stim = 32'h0080_FF7F;
    expv = 32'h7FFF_8000;
    rst8 = 1'b1;
    for (int i = 0; i < 32; i++) begin
      in8 = stim[i];
      tick();
      total++;
      if (out8 !== expv[i]) begin
        bad++;
        $display("FAIL sweep_n8 edge %0d: got %b want %b", i + 1, out8, expv[i]);
      end
    end
  endtask

  initial begin
    rst4 = 1'b0; in4 = 1'b0;
    rst2 = 1'b0; in2 = 1'b0;
    rst8 = 1'b0; in8 = 1'b0;
    tick();
    test_reset();
    test_rise();
    test_high_glitch();
    test_fall();
    test_idempotence();
    test_mid_reset();
    test_sweep_n2();
    test_sweep_n8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
